// File: rtl/addsub_pkg.sv
// Purpose : shared constants for the ripple add/subtract datapath slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package addsub_pkg;

    // Default operand/result width of the arithmetic slice.
    localparam int ADDSUB_DEFAULT_WIDTH = 16;

    // binvert encodings: add selects b, subtract selects ~b with carry-in 1.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/addsub_bitcell.sv
// Purpose : one bit of the ripple adder/subtractor (b/~b 2:1 select + full adder).
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
module addsub_bitcell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic binvert,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic bsel;

    // Operand select followed by a plain full adder.
    always_comb begin
        bsel = (binvert == OP_SUB) ? ~b : b;
        sum  = a ^ bsel ^ cin;
        cout = (a & bsel) | (a & cin) | (bsel & cin);
    end

endmodule : addsub_bitcell

// File: rtl/addsub_ripple_reg.sv
// Purpose : WIDTH-bit ripple-carry add/subtract with registered result and flags
//           (optional registered signed-less-than output under ADDSUB_SLT_EN).
// Latency : 1 cycle from in_valid to out_valid.
// Backpressure: none; every in_valid cycle is captured, idle cycles hold the last result.
module addsub_ripple_reg
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             binvert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
`ifdef ADDSUB_SLT_EN
    ,
    output logic             less
`endif
);

    // carry[i] is the carry into cell i; carry[0] supplies the +1 of two's-complement subtract.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             zero_comb;
    logic             overflow_comb;

    assign carry[0] = binvert;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            addsub_bitcell u_cell (
                .a       (a[i]),
                .b       (b[i]),
                .binvert (binvert),
                .cin     (carry[i]),
                .sum     (sum[i]),
                .cout    (carry[i+1])
            );
        end
    endgenerate

    // Flags from the full-width combinational sum; overflow is carry-in vs carry-out of the MSB.
    always_comb begin
        zero_comb     = (sum == '0);
        overflow_comb = carry[WIDTH] ^ carry[WIDTH-1];
    end

    // Valid tracks in_valid each edge; cleared immediately by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result and flags load only on valid cycles, so X operands while idle never reach them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result   <= '0;
            carryout <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (in_valid) begin
            result   <= sum;
            carryout <= carry[WIDTH];
            zero     <= zero_comb;
            overflow <= overflow_comb;
        end
    end

`ifdef ADDSUB_SLT_EN
    // Signed a < b when subtracting: sign of the difference corrected by overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            less <= 1'b0;
        end else if (in_valid) begin
            less <= sum[WIDTH-1] ^ overflow_comb;
        end
    end
`endif

endmodule : addsub_ripple_reg

// File: tb/tb_addsub_ripple_reg.sv
// Purpose : directed self-checking bench for addsub_ripple_reg and addsub_bitcell.
// Latency : checks results #1 after the capturing rising edge.
// Backpressure: none exercised; idle (in_valid=0) holding is checked instead.
module tb_addsub_ripple_reg;

    localparam int W = 16;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         binvert;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carryout;
    logic         zero;
    logic         overflow;
`ifdef ADDSUB_SLT_EN
    logic         less;
`endif

    logic bc_a, bc_b, bc_binvert, bc_cin, bc_sum, bc_cout;

    int total = 0;
    int bad   = 0;

    // {out_valid, result, carryout, zero, overflow}
    logic [W+3:0] obs;
    logic [W+3:0] exp_v;

    addsub_ripple_reg #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .binvert   (binvert),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .carryout  (carryout),
        .zero      (zero),
        .overflow  (overflow)
`ifdef ADDSUB_SLT_EN
        ,
        .less      (less)
`endif
    );

    addsub_bitcell u_bc (
        .a       (bc_a),
        .b       (bc_b),
        .binvert (bc_binvert),
        .cin     (bc_cin),
        .sum     (bc_sum),
        .cout    (bc_cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb obs = {out_valid, result, carryout, zero, overflow};

    task automatic test_reset();
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        exp_v = {1'b1 ^ 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset {vld,res,co,z,ov} got=%h exp=%h", obs, exp_v);
        end
`ifdef ADDSUB_SLT_EN
        total++;
        if (less !== 1'b0) begin
            bad++;
            $display("FAIL reset_less got=%b exp=0", less);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] va [2] = '{16'h0005, 16'hFFFF};
        logic [15:0] vb [2] = '{16'h0003, 16'h0001};
        logic [19:0] ve [2] = '{{1'b1, 16'h0008, 3'b000}, {1'b1, 16'h0000, 3'b110}};
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            a = va[k]; b = vb[k]; binvert = 1'b0; in_valid = 1'b1;
            @(posedge clock);
            #1;
            total++;
            if (obs !== ve[k]) begin
                bad++;
                $display("FAIL add[%0d] {vld,res,co,z,ov} got=%h exp=%h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_subtract();
        logic [15:0] va [4] = '{16'h0005, 16'h0003, 16'h1234, 16'h8000};
        logic [15:0] vb [4] = '{16'h0003, 16'h0005, 16'h1234, 16'h0001};
        logic [19:0] ve [4] = '{{1'b1, 16'h0002, 3'b100},
                                {1'b1, 16'hFFFE, 3'b000},
                                {1'b1, 16'h0000, 3'b110},
                                {1'b1, 16'h7FFF, 3'b101}};
        logic        vl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            a = va[k]; b = vb[k]; binvert = 1'b1; in_valid = 1'b1;
            @(posedge clock);
            #1;
            total++;
            if (obs !== ve[k]) begin
                bad++;
                $display("FAIL sub[%0d] {vld,res,co,z,ov} got=%h exp=%h", k, obs, ve[k]);
            end
`ifdef ADDSUB_SLT_EN
            total++;
            if (less !== vl[k]) begin
                bad++;
                $display("FAIL sub_less[%0d] got=%b exp=%b", k, less, vl[k]);
            end
`else
            if (vl[k] === 1'bx) $display("unexpected table entry %0d", k);
`endif
        end
    endtask

    task automatic test_overflow_hold();
        @(negedge clock);
        a = 16'h7FFF; b = 16'h0001; binvert = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        exp_v = {1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ovf {vld,res,co,z,ov} got=%h exp=%h", obs, exp_v);
        end
        // Idle with X operands: flags and result must hold.
        @(negedge clock);
        in_valid = 1'b0; a = 'x; b = 'x; binvert = 1'bx;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            exp_v = {1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold[%0d] {vld,res,co,z,ov} got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3] = '{16'h0001, 16'h00FF, 16'hABCD};
        logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0000};
        logic        vo [3] = '{1'b0, 1'b1, 1'b1};
        logic [19:0] ve [3] = '{{1'b1, 16'h0002, 3'b000},
                                {1'b1, 16'h00FE, 3'b100},
                                {1'b1, 16'hABCD, 3'b100}};
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            a = va[k]; b = vb[k]; binvert = vo[k]; in_valid = 1'b1;
            @(posedge clock);
            #1;
            total++;
            if (obs !== ve[k]) begin
                bad++;
                $display("FAIL b2b[%0d] {vld,res,co,z,ov} got=%h exp=%h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_reset_discard();
        @(negedge clock);
        a = 16'h0010; b = 16'h0020; binvert = 1'b0; in_valid = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1;
        exp_v = {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL rst_discard {vld,res,co,z,ov} got=%h exp=%h", obs, exp_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        exp_v = {1'b1, 16'h0030, 1'b0, 1'b0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL first_capture {vld,res,co,z,ov} got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_bitcell();
        logic [3:0] v;
        logic       bs;
        logic [1:0] tot;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            bc_a = v[3]; bc_b = v[2]; bc_binvert = v[1]; bc_cin = v[0];
            #1;
            bs  = v[1] ? ~v[2] : v[2];
            tot = 2'(v[3]) + 2'(bs) + 2'(v[0]);
            total++;
            if ({bc_cout, bc_sum} !== tot) begin
                bad++;
                $display("FAIL bitcell a=%b b=%b inv=%b cin=%b got={cout,sum}=%b%b exp=%b",
                         v[3], v[2], v[1], v[0], bc_cout, bc_sum, tot);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        binvert  = 1'b0;
        a        = '0;
        b        = '0;
        bc_a = 1'b0; bc_b = 1'b0; bc_binvert = 1'b0; bc_cin = 1'b0;
        test_reset();
        test_add();
        test_subtract();
        test_overflow_hold();
        test_back_to_back();
        test_reset_discard();
        test_bitcell();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_addsub_ripple_reg
